// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped down-counting timer that sits on the CPU data-memory port and
// provides an interrupt source. A 3-register window lives at BASE_ADDR:
//   +0 CTRL   [0] EN, [2:1] MODE (2'b01 = periodic, else one-shot), [3] IM
//   +4 PRESET 32-bit reload value
//   +8 COUNT  32-bit current count, read-only
// Reads are combinational. Writes are byte-lane merged and commit on posedge.
//
// Ports
//   clk     system clock, all state updates on posedge
//   reset   synchronous, active-high, clears all state
//   addr    byte address from the CPU data port (addr[1:0] ignored)
//   byteen  byte write enables, any bit set means a write
//   wdata   write data, byte lanes aligned
//   rdata   read data of the selected register, 0 on a miss
//   irq     registered interrupt request (pending flag gated by IM)
// ---------------------------------------------------------------------------
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    // Registered state
    state_t      state_q,    state_d;
    logic [3:0]  ctrl_q,     ctrl_d;
    logic [31:0] preset_q,   preset_d;
    logic [31:0] count_q,    count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q;

    // Bus decode
    logic       hit;
    logic       wr;
    logic       wr_ctrl;
    logic       wr_preset;
    logic [1:0] reg_sel;

    // Byte offset within a word carries no meaning for this device.
    logic addr_unused;
    assign addr_unused = ^addr[1:0];

    assign reg_sel   = addr[3:2];
    assign hit       = (addr[31:4] == BASE_ADDR[31:4]) && (reg_sel != 2'b11);
    assign wr        = hit && (byteen != 4'b0000);
    assign wr_ctrl   = wr && (reg_sel == REG_CTRL);
    assign wr_preset = wr && (reg_sel == REG_PRESET);

    // Combinational read mux
    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (reg_sel)
                REG_CTRL:   rdata = {28'h0, ctrl_q};
                REG_PRESET: rdata = preset_q;
                REG_COUNT:  rdata = count_q;
                default:    rdata = 32'h0;
            endcase
        end
    end

    // PRESET: independent byte-lane merge
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_preset_lane
            assign preset_d[gi*8 +: 8] = (wr_preset && byteen[gi]) ? wdata[gi*8 +: 8]
                                                                   : preset_q[gi*8 +: 8];
        end
    endgenerate

    // Counter FSM plus bus side effects. The bus write is applied after the
    // FSM so that a CPU write to CTRL overrides the FSM clearing EN, and a
    // CPU acknowledge overrides a same-cycle interrupt set.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        ctrl_d     = ctrl_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_IDLE;          // freeze COUNT where it is
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // 0 or 1 both terminate; COUNT never wraps.
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q[2:1] == MODE_PERIODIC) begin
                    irq_flag_d = 1'b0;          // single-cycle pulse
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;           // one-shot disarms, flag stays
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only lane 0 holds stored CTRL bits; upper lanes are not stored.
        if (wr_ctrl && byteen[0]) begin
            ctrl_d = wdata[3:0];
        end

        // Any write to CTRL or PRESET acknowledges a pending interrupt.
        if (wr_ctrl || wr_preset) begin
            irq_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 4'h0;
            preset_q   <= 32'h0;
            count_q    <= 32'h0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            // Mask applied to the next-state values so irq tracks the flag
            // and IM on the same edge.
            irq_q      <= irq_flag_d & ctrl_d[3];
        end
    end

    assign irq = irq_q;

endmodule
